// File: rtl/operand_capture_pkg.sv
// Shared types for the operand capture block: FSM phase encoding and debounce counter sizing.
package operand_capture_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } phase_t;

  // Counter must hold the value DEBOUNCE_CYCLES itself, so it never needs to wrap.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop sync, saturating stability counter, debounced level, registered fall pulse.
// Press pulse appears DEBOUNCE_CYCLES+3 edges after the raw key is first sampled low.
module key_debounce
  import operand_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int              CW      = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_fall;

  assign w_fall  = r_level_d & ~r_level;
  assign o_press = r_press;

  // A full count means DEBOUNCE_CYCLES consecutive disagreeing samples: flip and restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= w_fall;
      if (r_cnt == CNT_MAX) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (r_sync2 != r_level) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_capture.sv
// Captures two switch operands on debounced key presses (A, then B, then show) for a downstream adder/display.
// Registers update DEBOUNCE_CYCLES+4 edges after a stable key press; ab_valid strobes one cycle on B load.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_n,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ab_valid,
  output logic [1:0]       phase
);

  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ab_valid;
  phase_t           r_state;

  phase_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_abv_nxt;
  logic             w_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key_n(key_n),
    .o_press(w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD_A;
      r_a        <= '0;
      r_b        <= '0;
      r_ab_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_ab_valid <= w_abv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_abv_nxt   = 1'b0;
    case (r_state)
      LOAD_A: if (w_press) begin
        w_a_nxt     = r_sw_s2;
        w_state_nxt = LOAD_B;
      end
      LOAD_B: if (w_press) begin
        w_b_nxt     = r_sw_s2;
        w_abv_nxt   = 1'b1;
        w_state_nxt = SHOW;
      end
      SHOW: if (w_press) begin
        w_a_nxt     = r_sw_s2;
        w_b_nxt     = '0;
        w_state_nxt = LOAD_B;
      end
      // Illegal encoding recovers to the start of the sequence.
      default: w_state_nxt = LOAD_A;
    endcase
  end

  assign a        = r_a;
  assign b        = r_b;
  assign ab_valid = r_ab_valid;
  assign phase    = r_state;

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture with DEBOUNCE_CYCLES=4: directed scenarios plus random key/switch traffic vs a reference model.
module tb_operand_capture;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_n = 1'b1;
  logic [W-1:0] sw    = '0;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ab_valid;
  logic [1:0]   phase;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  operand_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .key_n   (key_n),
    .a       (a),
    .b       (b),
    .ab_valid(ab_valid),
    .phase   (phase)
  );

  // Reference model: a key level is accepted once the synchronized key has disagreed
  // with it for D samples; a high-to-low acceptance schedules one capture two edges later
  // using the switch value present at the acceptance edge.
  int           m_ph;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  bit           m_abv;
  bit           m_lvl;
  bit           m_pend;
  int           m_run;
  bit           kh1, kh2;
  longint       m_edge;
  longint       cap_due[$];
  logic [W-1:0] cap_sw[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_a = '0; m_b = '0; m_abv = 0;
      m_lvl = 1; m_pend = 0; m_run = 0; kh1 = 1; kh2 = 1; m_edge = 0;
      cap_due.delete(); cap_sw.delete();
    end else begin
      m_edge++;
      m_abv = 0;
      if (cap_due.size() > 0 && cap_due[0] == m_edge) begin
        case (m_ph)
          0:       begin m_a = cap_sw[0]; m_ph = 1; end
          1:       begin m_b = cap_sw[0]; m_abv = 1; m_ph = 2; end
          default: begin m_a = cap_sw[0]; m_b = '0; m_ph = 1; end
        endcase
        void'(cap_due.pop_front());
        void'(cap_sw.pop_front());
      end
      if (m_pend) begin
        m_lvl = !m_lvl; m_pend = 0; m_run = 0;
        if (!m_lvl) begin
          cap_due.push_back(m_edge + 2);
          cap_sw.push_back(sw);
        end
      end else if (kh2 != m_lvl) begin
        m_run++;
        if (m_run == D) m_pend = 1;
      end else begin
        m_run = 0;
      end
      kh2 = kh1;
      kh1 = key_n;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      tests++;
      if ({a, b, ab_valid, phase} !== {m_a, m_b, m_abv, 2'(m_ph)}) begin
        fails++;
        $display("FAIL model t=%0t: got a=%h b=%h v=%b ph=%b, expected a=%h b=%h v=%b ph=%0d",
                 $time, a, b, ab_valid, phase, m_a, m_b, m_abv, m_ph);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic assert_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic press(input logic [W-1:0] v);
    sw = v; key_n = 1'b0;
    tick(D + 6);
    key_n = 1'b1;
    tick(D + 8);
  endtask

  int nv, nchg;
  logic [W-1:0] pa, pb;

  initial begin
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_phase", 32'(phase), 32'h0);
    check("reset_a", 32'(a), 32'h0);

    // Pair load with exact latency: key sampled low from edge 0, update at edge D+4.
    sw = 8'h3C; key_n = 1'b0;
    tick(D + 4);
    check("lat_before_phase", 32'(phase), 32'h0);
    tick(1);
    check("lat_a", 32'(a), 32'h3C);
    check("lat_phase", 32'(phase), 32'h1);
    check("lat_abv", 32'(ab_valid), 32'h0);
    tick(1);
    key_n = 1'b1;
    tick(12);
    sw = 8'hC5; key_n = 1'b0;
    tick(D + 4);
    check("b_before_abv", 32'(ab_valid), 32'h0);
    tick(1);
    check("b_val", 32'(b), 32'hC5);
    check("b_abv", 32'(ab_valid), 32'h1);
    check("b_phase", 32'(phase), 32'h2);
    tick(1);
    check("b_abv_drop", 32'(ab_valid), 32'h0);
    check("b_hold_a", 32'(a), 32'h3C);
    tick(4);
    key_n = 1'b1;
    tick(12);

    // Bounce shorter than the debounce window is ignored; sw wiggle has no effect.
    sw = 8'h99;
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(2);
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(15);
    check("bounce_a", 32'(a), 32'h3C);
    check("bounce_b", 32'(b), 32'hC5);
    check("bounce_phase", 32'(phase), 32'h2);

    // Restart from SHOW.
    press(8'hFF);
    check("show_a", 32'(a), 32'hFF);
    check("show_b", 32'(b), 32'h00);
    check("show_phase", 32'(phase), 32'h1);
    check("show_abv", 32'(ab_valid), 32'h0);

    // Long hold then long release: one capture only.
    sw = 8'h5A; nv = 0; nchg = 0; pa = a; pb = b;
    key_n = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) key_n = 1'b1;
      tick(1);
      if (ab_valid) nv++;
      if (a !== pa || b !== pb) nchg++;
      pa = a; pb = b;
    end
    check("hold_valids", 32'(nv), 32'd1);
    check("hold_changes", 32'(nchg), 32'd1);
    check("hold_b", 32'(b), 32'h5A);
    check("hold_phase", 32'(phase), 32'h2);

    // Asynchronous reset mid-run takes effect without a clock edge.
    assert_reset();
    check("arst_a", 32'(a), 32'h0);
    check("arst_b", 32'(b), 32'h0);
    check("arst_phase", 32'(phase), 32'h0);
    check("arst_abv", 32'(ab_valid), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Reset mid-debounce in LOAD_B discards progress; next press loads A.
    press(8'h22);
    check("mid_pre_phase", 32'(phase), 32'h1);
    key_n = 1'b0;
    tick(3);
    assert_reset();
    check("mid_a", 32'(a), 32'h0);
    check("mid_phase", 32'(phase), 32'h0);
    tick(1);
    key_n = 1'b1;
    rst_n = 1'b1;
    tick(10);
    check("mid_nopress", 32'(phase), 32'h0);
    press(8'h11);
    check("mid_a2", 32'(a), 32'h11);
    check("mid_phase2", 32'(phase), 32'h1);

    // Key held low through reset release counts as a fresh press.
    sw = 8'h77; key_n = 1'b0;
    assert_reset();
    tick(1);
    rst_n = 1'b1;
    tick(D + 4);
    check("rel_before", 32'(phase), 32'h0);
    tick(1);
    check("rel_a", 32'(a), 32'h77);
    check("rel_phase", 32'(phase), 32'h1);
    key_n = 1'b1;
    tick(12);

    // Random traffic: mixes bounces and real presses, occasional resets.
    for (int s = 0; s < 350; s++) begin
      sw = W'($urandom);
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        assert_reset();
        tick(1);
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 10));
    end
    key_n = 1'b1;
    tick(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
